mem_image_loader: RTL and testbench

- Loads a program/data image into the CPU's word-addressed RAM (instruction or main memory) from a byte stream, then releases the CPU.
- It is the write side of the RAM dump path: words go into RAM in the same index order and format that the RAM dump reads out (one 32-bit word per index, index 0..511).
- Sits between the external stream source and the RAM write port; drives CPU_HOLD into the CPU's RESET/stall input.

---
 rtl/mem_image_loader_pkg.sv | 16 +
 rtl/mem_image_loader_word_assembler.sv | 32 +++
 rtl/mem_image_loader.sv | 129 ++++++++++++
 tb/tb_mem_image_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_image_loader_pkg.sv
// Shared constants and loader state encoding for the RAM image load path.
// DEPTH/ADDR_W are also consumed by the RAM and the RAM dump logic.
package mem_image_loader_pkg;
  localparam int DEPTH      = 512;
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int DATA_W     = 32;
  localparam int CHECKSUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } loader_state_e;
endpackage

// File: rtl/mem_image_loader_word_assembler.sv
// Packs four stream bytes into one big-endian RAM word; the first byte lands in the MSBs.
// word_o is combinational so the 4th byte is usable in the same cycle it is accepted.
module mem_image_loader_word_assembler
  import mem_image_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_en_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);
  logic [DATA_W-9:0] shift_q;
  logic [1:0]        cnt_q;

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_en_i && (cnt_q == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en_i) begin
      shift_q <= {shift_q[DATA_W-17:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end
endmodule

// File: rtl/mem_image_loader.sv
// Streams a byte image into word-addressed RAM, verifies an 8-bit additive trailer,
// and holds the CPU in reset until a clean load completes.
module mem_image_loader #(
  parameter int DEPTH  = mem_image_loader_pkg::DEPTH,
  parameter int ADDR_W = mem_image_loader_pkg::ADDR_W,
  parameter int DATA_W = mem_image_loader_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic [7:0]        byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o
);
  import mem_image_loader_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  loader_state_e         state_q;
  logic [ADDR_W:0]       count_q;
  logic [ADDR_W-1:0]     index_q;
  logic [CHECKSUM_W-1:0] csum_q;
  logic                  byte_ready_q, mem_we_q, done_q, error_q, cpu_hold_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;

  logic              accept, start_ok, asm_en, word_valid;
  logic [DATA_W-1:0] word;
  logic [ADDR_W:0]   index_inc;

  assign accept    = byte_valid_i && byte_ready_q;
  assign start_ok  = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign asm_en    = accept && (state_q == ST_RECV);
  assign index_inc = {1'b0, index_q} + 1'b1;

  mem_image_loader_word_assembler u_word_assembler (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (start_ok),
    .byte_i      (byte_in_i),
    .byte_en_i   (asm_en),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      index_q      <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            csum_q     <= '0;
            index_q    <= '0;
            cpu_hold_q <= 1'b1;
            count_q    <= word_count_i;
            if (word_count_i > DEPTH_L) begin
              // Oversized image is rejected without touching RAM.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else if (word_count_i == '0) begin
              state_q      <= ST_CHECK;
              byte_ready_q <= 1'b1;
            end else begin
              state_q      <= ST_RECV;
              byte_ready_q <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (accept) begin
            csum_q <= csum_q + byte_in_i;
            if (word_valid) begin
              state_q      <= ST_WRITE;
              byte_ready_q <= 1'b0;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= index_q;
              mem_wdata_q  <= word;
            end
          end
        end
        ST_WRITE: begin
          index_q      <= index_inc[ADDR_W-1:0];
          byte_ready_q <= 1'b1;
          state_q      <= (index_inc == count_q) ? ST_CHECK : ST_RECV;
        end
        ST_CHECK: begin
          if (accept) begin
            state_q      <= ST_DONE;
            byte_ready_q <= 1'b0;
            done_q       <= 1'b1;
            error_q      <= (byte_in_i != csum_q);
            cpu_hold_q   <= (byte_in_i != csum_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
endmodule

// File: tb/tb_mem_image_loader.sv
// Scoreboard bench: loads push expected RAM writes and results; a negedge monitor checks them.
module tb_mem_image_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, done, error;

  mem_image_loader dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .word_count_i(word_count),
    .byte_in_i(byte_in), .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .cpu_hold_o(cpu_hold), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] addr; logic [31:0] data; } wr_t;
  typedef struct { bit err; bit hold; } res_t;

  wr_t         exp_wr[$];
  res_t        exp_res[$];
  int          we_log[$];
  logic [31:0] ram_m [0:511];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  bit          armed = 0;
  bit          no_ready = 0;
  bit          we_prev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: consumes the scoreboard whenever the DUT writes RAM or reports completion.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        we_prev = 0;
      end else begin
        if (mem_we) begin
          wr_t e;
          chk("we_single_cycle", we_prev, 0);
          we_log.push_back(cyc);
          ram_m[mem_addr] = mem_wdata;
          chk("we_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_wdata, e.data);
          end
        end
        we_prev = mem_we;
        if (armed && done) begin
          res_t r;
          armed = 0;
          chk("res_expected", exp_res.size() > 0, 1);
          if (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            chk("error", error, r.err);
            chk("cpu_hold", cpu_hold, r.hold);
          end
        end
        if (no_ready) chk("no_ready", byte_ready, 0);
      end
    end
  end

  task automatic pulse_start(input int cnt);
    start = 1'b1;
    word_count = 10'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    armed = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    bit acc = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("byte_accept_timeout", 0, 1);
    if (gaps) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && armed; i++) begin
      @(posedge clk); #1;
    end
    chk("done_timeout", armed, 0);
  endtask

  // Reference: word i goes to index i; checksum is the byte sum mod 256.
  task automatic run_load(input int cnt, input logic [31:0] words[$], input bit corrupt,
                          input bit gaps);
    logic [7:0] sum = 8'h00;
    logic [7:0] trailer;
    int bad = 0;
    we_log.delete();
    for (int i = 0; i < cnt; i++) begin
      exp_wr.push_back('{addr: 9'(i), data: words[i]});
      for (int k = 0; k < 4; k++) sum = sum + words[i][31-8*k -: 8];
    end
    trailer = corrupt ? 8'(sum + 8'($urandom_range(1, 255))) : sum;
    exp_res.push_back('{err: corrupt, hold: corrupt});
    pulse_start(cnt);
    for (int i = 0; i < cnt; i++)
      for (int k = 0; k < 4; k++) send_byte(words[i][31-8*k -: 8], gaps);
    send_byte(trailer, gaps);
    byte_valid = 1'b0;
    wait_done();
    chk("done_level", done, 1);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("we_count", we_log.size(), cnt);
    if (!gaps) begin
      for (int i = 1; i < we_log.size(); i++)
        if (we_log[i] - we_log[i-1] != 5) bad++;
      chk("we_spacing_bad", bad, 0);
    end
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] old1;
    for (int i = 0; i < 512; i++) ram_m[i] = 32'hDEAD_0000 + 32'(i);
    rst = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    #12;
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_hold", cpu_hold, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed two-word image, clean then corrupted trailer.
    w = '{32'h12345678, 32'h9ABCDEF0};
    run_load(2, w, 0, 0);
    chk("ram0", ram_m[0], 32'h12345678);
    chk("ram1", ram_m[1], 32'h9ABCDEF0);
    run_load(2, w, 1, 0);

    // Oversized count: immediate error, no handshake, no writes.
    we_log.delete();
    no_ready = 1;
    exp_res.push_back('{err: 1, hold: 1});
    pulse_start(513);
    @(negedge clk); #1;
    chk("ovf_immediate", armed, 0);
    chk("ovf_done", done, 1);
    repeat (4) @(posedge clk);
    #1;
    no_ready = 0;
    chk("ovf_no_we", we_log.size(), 0);

    // Empty image: only the trailer.
    w = {};
    run_load(0, w, 0, 0);

    // Stalled stream gives the same result.
    w = '{32'h12345678, 32'h9ABCDEF0};
    run_load(2, w, 0, 1);

    // Reset after six bytes: word 0 written, word 1 untouched.
    old1 = ram_m[1];
    w = '{$urandom, $urandom};
    exp_wr.push_back('{addr: 9'd0, data: w[0]});
    pulse_start(2);
    armed = 0;
    for (int i = 0; i < 6; i++) send_byte(w[i/4][31-8*(i%4) -: 8], 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_ram0", ram_m[0], w[0]);
    chk("mid_rst_ram1", ram_m[1], old1);
    chk("mid_rst_queue", exp_wr.size(), 0);
    byte_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    w = '{$urandom, $urandom, $urandom};
    run_load(3, w, 0, 0);

    // Randomized loads.
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(1, 6);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_load(n, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Full-depth image reaches index DEPTH-1.
    w = {};
    for (int i = 0; i < 512; i++) w.push_back($urandom);
    run_load(512, w, 0, 0);
    chk("ram_last", ram_m[511], w[511]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
